// File: rtl/cla_seq_pkg.sv
// Shared types and sizing for the slice-sequenced 64-bit adder.
// Also holds the lookahead carry helper used by the 16-bit slice.
package cla_seq_pkg;

    localparam int SLICE_W  = 16;
    localparam int N_SLICES = 4;
    localparam int W        = SLICE_W * N_SLICES;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    // Carry into position n of a 4-wide generate/propagate group.
    function automatic logic la4(
        input logic [3:0] g,
        input logic [3:0] p,
        input logic       c0,
        input int         n
    );
        logic c;
        c = c0;
        for (int t = 0; t < 4; t++) begin
            if (t < n) c = g[t] | (p[t] & c);
        end
        return c;
    endfunction

endpackage

// File: rtl/cla16_slice.sv
// Combinational 16-bit carry-lookahead slice built from four
// 4-bit lookahead groups with a second-level group lookahead.
module cla16_slice
    import cla_seq_pkg::*;
(
    input  logic [SLICE_W-1:0] x,
    input  logic [SLICE_W-1:0] y,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout
);

    localparam int NG = SLICE_W / 4;

    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] p;
    logic [NG-1:0]      gg;
    logic [NG-1:0]      gp;
    logic [NG-1:0]      gc;

    assign g = x & y;
    assign p = x ^ y;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int j = 0; j < NG; j++) begin
            gg[j] = la4(g[4*j +: 4], p[4*j +: 4], 1'b0, 4);
            gp[j] = &p[4*j +: 4];
        end
    end

    always_comb begin
        gc = '0;
        for (int j = 0; j < NG; j++) begin
            gc[j] = la4(gg, gp, cin, j);
        end
    end

    always_comb begin
        s = '0;
        for (int j = 0; j < NG; j++) begin
            for (int l = 0; l < 4; l++) begin
                s[4*j+l] = p[4*j+l] ^ la4(g[4*j +: 4], p[4*j +: 4], gc[j], l);
            end
        end
    end

    assign cout = la4(gg, gp, cin, NG);

endmodule

// File: rtl/cla64_seq_adder.sv
// 64-bit add/sub that reuses one 16-bit CLA slice over four cycles,
// low slice first, with the inter-slice carry kept in carry_r.
module cla64_seq_adder
    import cla_seq_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         sub,
    input  logic         cin,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         ovf
);

    localparam int KW = $clog2(N_SLICES);

    state_t             state;
    logic [W-1:0]       a_r;
    logic [W-1:0]       b_r;
    logic [W-1:0]       sum_r;
    logic               carry_r;
    logic               cout_r;
    logic               ovf_r;
    logic               in_ready_r;
    logic               out_valid_r;
    logic [KW-1:0]      k;
    logic [SLICE_W-1:0] sx;
    logic [SLICE_W-1:0] sy;
    logic [SLICE_W-1:0] ss;
    logic               sc;

    assign sx = a_r[k*SLICE_W +: SLICE_W];
    assign sy = b_r[k*SLICE_W +: SLICE_W];

    cla16_slice u_slice (
        .x    (sx),
        .y    (sy),
        .cin  (carry_r),
        .s    (ss),
        .cout (sc)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            a_r         <= '0;
            b_r         <= '0;
            sum_r       <= '0;
            carry_r     <= 1'b0;
            cout_r      <= 1'b0;
            ovf_r       <= 1'b0;
            k           <= '0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r        <= a;
                        b_r        <= b ^ {W{sub}};
                        carry_r    <= sub | cin;
                        k          <= '0;
                        in_ready_r <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    sum_r[k*SLICE_W +: SLICE_W] <= ss;
                    carry_r <= sc;
                    k       <= k + KW'(1);
                    // Last slice: its sign bit decides overflow.
                    if (k == KW'(N_SLICES - 1)) begin
                        cout_r      <= sc;
                        ovf_r       <= (a_r[W-1] == b_r[W-1]) &&
                                       (ss[SLICE_W-1] != a_r[W-1]);
                        out_valid_r <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign sum       = sum_r;
    assign cout      = cout_r;
    assign ovf       = ovf_r;

endmodule

// File: tb/tb_cla64_seq_adder.sv
// Self-checking bench for cla64_seq_adder: directed vectors, handshake
// corner cases and random back-to-back traffic against a wide-arithmetic model.
module tb_cla64_seq_adder;

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
    } res_t;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic        sub;
        logic        cin;
        logic [63:0] e_sum;
        logic        e_cout;
        logic        e_ovf;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] a;
    logic [63:0] b;
    logic        sub;
    logic        cin;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;

    int n_cmp = 0;
    int n_bad = 0;

    cla64_seq_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Exact wide-integer arithmetic; overflow means the true signed
    // result does not fit back into 64 bits.
    function automatic res_t model(input logic [63:0] x, input logic [63:0] y,
                                   input logic s, input logic c);
        res_t r;
        logic signed [65:0] sx;
        logic signed [65:0] sy;
        logic signed [65:0] sr;
        logic signed [65:0] sw;
        logic [64:0]        u;
        sx = $signed({{2{x[63]}}, x});
        sy = $signed({{2{y[63]}}, y});
        if (s) begin
            r.sum  = x - y;
            r.cout = (x >= y);
            sr     = sx - sy;
        end else begin
            u      = {1'b0, x} + {1'b0, y} + {64'd0, c};
            r.sum  = u[63:0];
            r.cout = u[64];
            sr     = sx + sy + $signed({65'd0, c});
        end
        sw    = $signed({{2{r.sum[63]}}, r.sum});
        r.ovf = (sr != sw);
        return r;
    endfunction

    task automatic rand_ops();
        logic [31:0] r;
        r   = $urandom();
        a   = {$urandom(), $urandom()};
        b   = {$urandom(), $urandom()};
        if (r[2:0] == 3'd0) a = '1;
        if (r[5:3] == 3'd0) b = 64'd1;
        if (r[8:6] == 3'd0) a = 64'h7FFF_FFFF_FFFF_FFFF;
        sub = r[9];
        cin = r[10];
    endtask

    // Called at a negedge; returns at the negedge after the result is consumed.
    task automatic run_op(input logic [63:0] x, input logic [63:0] y,
                          input logic s, input logic c,
                          output res_t r, output int lat);
        int w;
        w = 0;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            n_cmp++;
            n_bad++;
            $display("FAIL accept_timeout: in_ready got 0 required 1");
        end
        a         = x;
        b         = y;
        sub       = s;
        cin       = c;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        rand_ops();
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r.sum  = sum;
        r.cout = cout;
        r.ovf  = ovf;
        @(negedge clk);
    endtask

    vec_t vecs[8];
    res_t got;
    res_t exp_r;
    int   lat;
    res_t q[$];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'd0, 1'b1, 1'b0};
        vecs[1] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[2] = '{64'd5, 64'd7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
        vecs[3] = '{64'd7, 64'd5, 1'b1, 1'b0, 64'd2, 1'b1, 1'b0};
        vecs[4] = '{64'd3, 64'd4, 1'b0, 1'b0, 64'd7, 1'b0, 1'b0};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0,
                    64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1};
        vecs[6] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                    64'd0, 1'b1, 1'b1};
        vecs[7] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
                    64'h0000_0000_0001_0000, 1'b0, 1'b0};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        sub       = 1'b0;
        cin       = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_sum", sum, 64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);

        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].cin, got, lat);
            chk($sformatf("vec%0d_sum", i), got.sum, vecs[i].e_sum);
            chk($sformatf("vec%0d_cout", i), 64'(got.cout), 64'(vecs[i].e_cout));
            chk($sformatf("vec%0d_ovf", i), 64'(got.ovf), 64'(vecs[i].e_ovf));
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd4);
        end

        // Backpressure with ignored in_valid pulses during RUN and DONE.
        out_ready = 1'b0;
        a         = vecs[1].a;
        b         = vecs[1].b;
        sub       = vecs[1].sub;
        cin       = vecs[1].cin;
        in_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            rand_ops();
            in_valid = (i % 2 == 0);
            chk("bp_run_in_ready", 64'(in_ready), 64'd0);
            chk("bp_run_out_valid", 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            in_valid = 1'b1;
            chk("bp_hold_out_valid", 64'(out_valid), 64'd1);
            chk("bp_hold_in_ready", 64'(in_ready), 64'd0);
            chk("bp_hold_sum", sum, vecs[1].e_sum);
            chk("bp_hold_cout", 64'(cout), 64'(vecs[1].e_cout));
            chk("bp_hold_ovf", 64'(ovf), 64'(vecs[1].e_ovf));
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_out_valid", 64'(out_valid), 64'd0);
        chk("bp_release_in_ready", 64'(in_ready), 64'd1);

        // Reset after two slices of an operation.
        a        = 64'h0001_0002_0003_0004;
        b        = 64'd1;
        sub      = 1'b0;
        cin      = 1'b0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", 64'(out_valid), 64'd0);
        chk("midrst_sum", sum, 64'd0);
        chk("midrst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("postrst_out_valid", 64'(out_valid), 64'd0);
        run_op(64'd3, 64'd4, 1'b0, 1'b0, got, lat);
        chk("postrst_sum", got.sum, 64'd7);
        chk("postrst_latency", 64'(lat), 64'd4);

        // Back-to-back random traffic with in_valid and out_ready held high.
        begin
            int cyc;
            int acc;
            int issued;
            int done;
            cyc       = 0;
            acc       = 0;
            issued    = 0;
            done      = 0;
            out_ready = 1'b1;
            while (done < 100 && cyc < 3000) begin
                if (out_valid) begin
                    if (q.size() == 0) begin
                        n_cmp++;
                        n_bad++;
                        $display("FAIL b2b_extra: out_valid with no pending op");
                    end else begin
                        exp_r = q.pop_front();
                        chk("b2b_sum", sum, exp_r.sum);
                        chk("b2b_cout", 64'(cout), 64'(exp_r.cout));
                        chk("b2b_ovf", 64'(ovf), 64'(exp_r.ovf));
                        chk("b2b_latency", 64'(cyc - acc), 64'd5);
                    end
                    done++;
                end
                rand_ops();
                in_valid = (issued < 100);
                if (in_ready && issued < 100) begin
                    q.push_back(model(a, b, sub, cin));
                    acc = cyc;
                    issued++;
                end
                @(negedge clk);
                cyc++;
            end
            in_valid = 1'b0;
            if (done < 100) begin
                n_cmp++;
                n_bad++;
                $display("FAIL b2b_timeout: completed %0d required 100", done);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
